// File: rtl/barrel_rotl_pipe_if.sv
// rtl/barrel_rotl_pipe_if.sv - valid/ready bundle for the pipelined left rotator
interface barrel_rotl_pipe_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shift;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;

  modport master (
    output in_valid, in, shift, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, shift, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/barrel_rotl_pipe.sv
// rtl/barrel_rotl_pipe.sv - log2(WIDTH)-stage left rotator with collapsing valid/ready pipe
module barrel_rotl_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input logic               clk,
  input logic               rst_n,
  barrel_rotl_pipe_if.slave bus
);
  logic [SHW-1:0]            v;
  logic [SHW-1:0]            ld;
  logic [SHW-1:0]            src_v;
  logic [SHW-1:0][WIDTH-1:0] d;
  logic [SHW-1:0][WIDTH-1:0] src_d;
  logic [SHW-1:0][WIDTH-1:0] rot_d;
  logic [SHW-1:0][SHW-1:0]   s;
  logic [SHW-1:0][SHW-1:0]   src_s;
  logic                      full_run;
  logic                      unused_shift;

  // Stage k rotates by 2^k when bit k of the shift it carries is set.
  always_comb begin
    src_v[0] = bus.in_valid;
    src_d[0] = bus.in;
    src_s[0] = bus.shift;
    for (int k = 1; k < SHW; k++) begin
      src_v[k] = v[k-1];
      src_d[k] = d[k-1];
      src_s[k] = s[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      rot_d[k] = src_s[k][k] ? ((src_d[k] << (1 << k)) | (src_d[k] >> (WIDTH - (1 << k))))
                             : src_d[k];
    end
  end

  // A stage may load when it or any stage downstream of it is empty, or the output drains.
  always_comb begin
    full_run = 1'b1;
    for (int k = SHW - 1; k >= 0; k--) begin
      full_run = full_run & v[k];
      ld[k]    = bus.out_ready | ~full_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      d <= '0;
      s <= '0;
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (ld[k]) begin
          v[k] <= src_v[k];
          if (src_v[k]) begin
            d[k] <= rot_d[k];
            s[k] <= src_s[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v[SHW-1];
  assign bus.out       = d[SHW-1];

  // Consumed shift bits and the last stage's copy are kept only for visibility.
  assign unused_shift = ^s;
endmodule
